pulse_event_arbiter: RTL and testbench

- Collects single-bit event pulses from NUM_CH asynchronous sources into the clk_dst domain.
- Each source passes through its own SYNC_STAGES-deep synchronizer and a rising-edge detector.
- Detected events are held as pending flags and serialized round-robin onto one valid/ready event channel, tagged with the source index.
- Sits between multiple pulse-sync consumers and a single downstream event handler (interrupt/status logic).

---
 rtl/pulse_event_arbiter.sv | 131 +++++++++++++
 tb/tb_pulse_event_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_arbiter.sv
// Synchronizes NUM_CH async pulses, latches rising edges as pending events and serializes them
// onto one valid/ready channel. Define PULSE_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
module pulse_event_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_dst,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] pulse_src,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ID_W-1:0]   evt_id,
    output logic [NUM_CH-1:0] evt_overflow,
    input  logic              ovf_clr,
    output logic              busy
);

    // state  | meaning
    // IDLE   | nothing offered, arbitrate as soon as any event is pending
    // OFFER  | evt_id offered downstream, held until accepted
    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t            state_q;
    logic              evt_valid_q;
    logic [ID_W-1:0]   evt_id_q;
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] remaining;
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   gidx;
    logic              found;
    logic              hs;

    assign hs           = evt_valid_q & evt_ready;
    assign rise         = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign acc          = hs ? (NUM_CH'(1) << evt_id_q) : '0;
    assign remaining    = pending_q & ~acc;
    assign pending_d    = remaining | rise;
    assign ovf_d        = (ovf_q & ~{NUM_CH{ovf_clr}}) | (rise & remaining);

    assign evt_valid    = evt_valid_q;
    assign evt_id       = evt_id_q;
    assign evt_overflow = ovf_q;
    assign busy         = (|pending_q) | evt_valid_q;

`ifdef PULSE_ARB_FIXED_PRIO_EN
    assign ptr_nxt = '0;
`else
    logic [ID_W-1:0] rr_q;

    assign ptr_nxt = hs ? ID_W'((int'(evt_id_q) + 1) % NUM_CH) : rr_q;

    always_ff @(posedge clk_dst or negedge rstn) begin
        if (!rstn) begin
            rr_q <= '0;
        end else if (hs) begin
            rr_q <= ptr_nxt;
        end
    end
`endif

    // Search starts at the pointer and wraps; the just-accepted channel is excluded.
    always_comb begin
        int idx;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = (int'(ptr_nxt) + off) % NUM_CH;
            if (!found && remaining[idx]) begin
                found = 1'b1;
                gidx  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_dst or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            sync_q[0] <= pulse_src;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q    <= sync_q[SYNC_STAGES-1];
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk_dst or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q     <= S_OFFER;
                        evt_valid_q <= 1'b1;
                        evt_id_q    <= gidx;
                    end
                end
                S_OFFER: begin
                    if (hs) begin
                        if (found) begin
                            evt_id_q <= gidx;
                        end else if (!rise[evt_id_q]) begin
                            // a re-risen evt_id keeps the offer alive with the same id
                            state_q     <= S_IDLE;
                            evt_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Scoreboard bench for pulse_event_arbiter: a delay-line/array reference model predicts offers
// and flag values; a negedge monitor pops expected ids on each handshake.
module tb_pulse_event_arbiter;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int IW = 2;

    logic          clk_dst   = 1'b0;
    logic          rstn      = 1'b0;
    logic [N-1:0]  pulse_src = '0;
    logic          evt_ready = 1'b0;
    logic          ovf_clr   = 1'b0;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic [N-1:0]  evt_overflow;
    logic          busy;

    pulse_event_arbiter #(.NUM_CH(N), .ID_W(IW), .SYNC_STAGES(S)) dut (
        .clk_dst      (clk_dst),
        .rstn         (rstn),
        .pulse_src    (pulse_src),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr),
        .busy         (busy)
    );

    always #10 clk_dst = ~clk_dst;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [N-1:0] m_hist[$];   // past input samples, oldest first
    bit [N-1:0] m_pend;
    bit [N-1:0] m_ovf;
    bit         m_valid;
    int         m_id;
    int         m_ptr;
    int         exp_q[$];
    int         seen_q[$];

    function automatic int pick(input bit [N-1:0] v, input int ptr);
        for (int off = 0; off < N; off++)
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        return 0;
    endfunction

    task automatic m_reset();
        m_hist.delete();
        repeat (S + 1) m_hist.push_back('0);
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_id    = 0;
        m_ptr   = 0;
        exp_q.delete();
    endtask

    task automatic m_step();
        bit [N-1:0] rise, rem, new_pend, new_ovf;
        bit hs;
        rise = m_hist[1] & ~m_hist[0];
        hs   = m_valid && evt_ready;
        rem  = m_pend;
        if (hs) rem[m_id] = 1'b0;
        new_pend = rem | rise;
        new_ovf  = (ovf_clr ? '0 : m_ovf) | (rise & rem);
        if (!m_valid) begin
            if (m_pend != 0) begin
                m_id    = pick(m_pend, m_ptr);
                m_valid = 1'b1;
                exp_q.push_back(m_id);
            end
        end else if (hs) begin
`ifdef PULSE_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (m_id + 1) % N;
`endif
            if (rem != 0) begin
                m_id = pick(rem, m_ptr);
                exp_q.push_back(m_id);
            end else if (rise[m_id]) begin
                exp_q.push_back(m_id);
            end else begin
                m_valid = 1'b0;
            end
        end
        m_pend = new_pend;
        m_ovf  = new_ovf;
        m_hist.push_back(pulse_src);
        void'(m_hist.pop_front());
    endtask

    always @(posedge clk_dst or negedge rstn) begin
        if (!rstn) m_reset();
        else       m_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk_dst) begin
        if (rstn) begin
            chk("valid", evt_valid, m_valid);
            chk("busy", busy, (m_pend != 0) || m_valid);
            chk("overflow", evt_overflow, m_ovf);
            if (evt_valid && evt_ready) begin
                chk("sb_expected_event", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("sb_id", evt_id, exp_q.pop_front());
                seen_q.push_back(int'(evt_id));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_dst);
            #5;
        end
    endtask

    initial begin
        int lat, vc;
        bit [N-1:0] mask;
        m_reset();
        step(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_ovf", evt_overflow, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1;
        step(2);

        // single pulse on ch0, 40 ns wide
        evt_ready = 1'b1;
        pulse_src = 4'b0001;
        lat = 0;
        vc  = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_dst);
            if (evt_valid) begin
                vc++;
                if (lat == 0) lat = c;
            end
            @(posedge clk_dst);
            #5;
            if (c == 2) pulse_src = '0;
        end
        chk("latency_negedges", lat, 5);
        chk("valid_cycles", vc, 1);
        chk("idle_busy", busy, 0);

        // simultaneous ch1..ch3
        seen_q.delete();
        pulse_src = 4'b1110;
        step(2);
        pulse_src = '0;
        step(8);
        chk("burst_count", seen_q.size(), 3);
        for (int i = 0; i < 3 && i < seen_q.size(); i++) chk("burst_order", seen_q[i], i + 1);

        // ch0 and ch3 repeatedly pending
        seen_q.delete();
        repeat (4) begin
            pulse_src = 4'b1001;
            step(2);
            pulse_src = '0;
            step(2);
        end
        step(6);
        chk("alt_count", seen_q.size() >= 4, 1);
        if (seen_q.size() >= 4) begin
            chk("alt_0", seen_q[0], 0);
            chk("alt_1", seen_q[1], 3);
            chk("alt_2", seen_q[2], 0);
            chk("alt_3", seen_q[3], 3);
        end

        // backpressure on ch2
        seen_q.delete();
        evt_ready = 1'b0;
        pulse_src = 4'b0100;
        step(2);
        pulse_src = '0;
        step(12);
        chk("hold_valid", evt_valid, 1);
        chk("hold_id", evt_id, 2);
        evt_ready = 1'b1;
        step(5);
        chk("hold_accepted_once", seen_q.size(), 1);
        chk("hold_busy", busy, 0);

        // coalescing on ch1
        seen_q.delete();
        evt_ready = 1'b0;
        pulse_src = 4'b0010; step(2);
        pulse_src = '0;      step(2);
        pulse_src = 4'b0010; step(2);
        pulse_src = '0;      step(4);
        chk("ovf_set", evt_overflow, 4'b0010);
        evt_ready = 1'b1;
        step(4);
        chk("ovf_one_event", seen_q.size(), 1);
        ovf_clr = 1'b1; step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", evt_overflow, 4'b0000);
        evt_ready = 1'b0;
        pulse_src = 4'b0010; step(2);
        pulse_src = '0;      step(4);
        pulse_src = 4'b0010; step(2);
        pulse_src = '0;
        ovf_clr   = 1'b1;    step(1);
        ovf_clr   = 1'b0;
        chk("ovf_set_wins", evt_overflow, 4'b0010);
        evt_ready = 1'b1;
        step(4);
        ovf_clr = 1'b1; step(1);
        ovf_clr = 1'b0;

        // reset during OFFER of ch2
        evt_ready = 1'b0;
        pulse_src = 4'b0100; step(2);
        pulse_src = '0;
        for (int c = 0; c < 10 && !evt_valid; c++) step(1);
        chk("pre_rst_valid", evt_valid, 1);
        chk("pre_rst_id", evt_id, 2);
        rstn = 1'b0;
        #1;
        chk("async_rst_valid", evt_valid, 0);
        chk("async_rst_id", evt_id, 0);
        chk("async_rst_busy", busy, 0);
        step(2);
        rstn = 1'b1;
        evt_ready = 1'b1;
        seen_q.delete();
        step(10);
        chk("no_replay", seen_q.size(), 0);

        // ch0 and ch3 continuously re-pulsed
        repeat (10) begin
            pulse_src = 4'b1001; step(1);
            pulse_src = '0;      step(1);
        end
        step(8);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mask = '0;
            for (int b = 0; b < N; b++) mask[b] = ($urandom_range(0, 3) == 0);
            pulse_src = pulse_src ^ mask;
            evt_ready = ($urandom_range(0, 9) < 7);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rstn = 1'b0;
                step(1);
                rstn = 1'b1;
            end
            step(1);
        end

        pulse_src = '0;
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        step(20);
        chk("sb_drained", exp_q.size(), 0);
        chk("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
